// File: rtl/data_mem_arbiter_pkg.sv
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared memory-op encodings, widths and helpers for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_arbiter_pkg;

   localparam int MEM_OP_BITS = 2;
   localparam int ADDR_WIDTH  = 8;
   localparam int DATA_WIDTH  = 32;

   typedef logic [MEM_OP_BITS-1:0] mem_op_t;

   localparam mem_op_t MEM_OP_NOP   = 2'd0;
   localparam mem_op_t MEM_OP_READ  = 2'd1;
   localparam mem_op_t MEM_OP_WRITE = 2'd2;

   // Width needed to hold the values 0..limit inclusive.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_wait_counter.sv
// ============================================================================
// Module      : arb_wait_counter
// Description : Saturating refusal counter; at_limit flags LIMIT reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_wait_counter
   import data_mem_arbiter_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int               CNT_W   = cnt_width(LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear dominates increment; increment stops at the limit.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit = (count_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Arbitrates the single-port data RAM between the MEM stage and
//               a debug/loader port with halt and anti-starvation slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = ADDR_WIDTH,
   parameter int DATA_W       = DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [MEM_OP_BITS-1:0] cpu_mem_op,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   cpu_stall,
   input  logic                   dbg_valid,
   input  logic                   dbg_write,
   input  logic [ADDR_W-1:0]      dbg_addr,
   input  logic [DATA_W-1:0]      dbg_wdata,
   output logic                   dbg_ready,
   output logic                   dbg_rvalid,
   output logic [DATA_W-1:0]      dbg_rdata,
   input  logic                   dbg_halt_req,
   output logic                   dbg_halted,
   output logic [ADDR_W-1:0]      ram_address,
   output logic [DATA_W-1:0]      ram_write_data,
   output logic [MEM_OP_BITS-1:0] ram_mem_op,
   input  logic [DATA_W-1:0]      ram_read_data
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]        state_q;
   logic [0:0]        state_d;
   logic              dbg_rvalid_q;
   logic              dbg_rvalid_d;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] cpu_rdata_d;

   logic cpu_active;
   logic in_halt;
   logic at_limit;
   logic forced_slot;
   logic dbg_grant;
   logic cpu_grant;
   logic wait_inc;
   logic wait_clr;

   always_comb begin
      cpu_active  = (cpu_mem_op != MEM_OP_NOP);
      in_halt     = (state_q == ST_HALT);
      forced_slot = !in_halt && at_limit && dbg_valid;
      // Reset gates every grant so the RAM sees NOP while reset is held.
      dbg_grant   = !reset && (in_halt ? dbg_valid
                                       : (forced_slot || (!cpu_active && dbg_valid)));
      cpu_grant   = !reset && !in_halt && !forced_slot && cpu_active;
      wait_inc    = !in_halt && dbg_valid && !dbg_grant;
      wait_clr    = dbg_grant || !dbg_valid;
   end

   always_comb begin
      ram_address    = cpu_addr;
      ram_write_data = cpu_wdata;
      ram_mem_op     = MEM_OP_NOP;
      if (dbg_grant) begin
         ram_address    = dbg_addr;
         ram_write_data = dbg_wdata;
         ram_mem_op     = dbg_write ? MEM_OP_WRITE : MEM_OP_READ;
      end else if (cpu_grant) begin
         ram_mem_op = cpu_mem_op;
      end
   end

   always_comb begin
      state_d      = dbg_halt_req ? ST_HALT : ST_RUN;
      dbg_rvalid_d = dbg_grant && !dbg_write;
      dbg_rdata_d  = dbg_rvalid_d ? ram_read_data : dbg_rdata_q;
      cpu_rdata_d  = cpu_grant ? ram_read_data : cpu_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         dbg_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
         cpu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         dbg_rdata_q  <= dbg_rdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   arb_wait_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (wait_inc),
      .clr      (wait_clr),
      .at_limit (at_limit)
   );

   assign cpu_rdata  = cpu_rdata_d;
   assign cpu_stall  = !reset && (in_halt || forced_slot);
   assign dbg_ready  = dbg_grant;
   assign dbg_halted = in_halt;
   assign dbg_rvalid = dbg_rvalid_q;
   assign dbg_rdata  = dbg_rdata_q;

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data `ram` between two requesters: the processor's MEM stage and an external debug/loader port. The debug port can preload and inspect memory, and can halt the pipeline for exclusive access. The block sits between the `ex_mem_register` outputs and the `ram` instance. It also produces a pipeline-freeze signal that the PC, all pipeline registers and the register-file write path must honour.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive cycles a pending debug request may be refused before it is forced through (≥1).
- `ADDR_W`, `` `ADDR_WIDTH ``: address width.
- `DATA_W`, `` `DATA_WIDTH ``: data width.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_mem_op` in `` `MEM_OP_BITS ``: MEM-stage operation (from `ex_mem_mem_op`).
- `cpu_addr` in ADDR_W: MEM-stage address.
- `cpu_wdata` in DATA_W: MEM-stage store data.
- `cpu_rdata` out DATA_W: read data to `mem_wb_register`.
- `cpu_stall` out 1: freeze PC and all pipeline registers this cycle.
- `dbg_valid` in 1: debug request present.
- `dbg_write` in 1: 1 = write, 0 = read.
- `dbg_addr` in ADDR_W: debug address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_ready` out 1: request accepted this cycle (valid && ready = transfer).
- `dbg_rvalid` out 1: registered read-response strobe.
- `dbg_rdata` out DATA_W: registered read data.
- `dbg_halt_req` in 1: level; request exclusive ownership.
- `dbg_halted` out 1: pipeline halted, debug owns ram.
- `ram_address` out ADDR_W, `ram_write_data` out DATA_W, `ram_mem_op` out `` `MEM_OP_BITS ``: to `ram`.
- `ram_read_data` in DATA_W: combinational read data from `ram`.

## Operation
- `cpu_active` = (`cpu_mem_op` != `MEM_OP_NOP`).
- FSM states: RUN and HALT.
- RUN → HALT on any cycle with `dbg_halt_req`=1. HALT → RUN on a cycle with `dbg_halt_req`=0.
- Grant in RUN:
  - If `wait_cnt` == STARVE_LIMIT and `dbg_valid`: debug is granted and `cpu_stall`=1 (forced slot).
  - Else if `cpu_active`: CPU is granted and `dbg_ready`=0.
  - Else if `dbg_valid`: debug is granted.
  - Else: ram op = NOP.
- Grant in HALT: debug is granted whenever `dbg_valid`. `cpu_stall`=1 and `dbg_halted`=1 every HALT cycle. `cpu_mem_op` is ignored.
- CPU grant:
  - ram port = cpu_addr / cpu_wdata / cpu_mem_op.
  - `cpu_rdata` = `ram_read_data`.
- Debug grant:
  - ram port = dbg_addr / dbg_wdata / (`dbg_write` ? `MEM_OP_WRITE` : `MEM_OP_READ`).
  - `dbg_ready`=1.
  - `cpu_rdata` holds its last CPU value; it is don't-care because the CPU is stalled or idle.
- `wait_cnt`:
  - Increments (saturating at STARVE_LIMIT) each RUN cycle with `dbg_valid` && !`dbg_ready`.
  - Clears on any debug grant, and whenever `dbg_valid`=0.
- A stalled CPU access replays the following cycle from the frozen `ex_mem_register`, so CPU ordering is preserved after the debug slot.
- Read response: on an accepted debug read, `dbg_rvalid`=1 and `dbg_rdata`=`ram_read_data` on the next cycle. Otherwise `dbg_rvalid`=0 and `dbg_rdata` holds.

## Timing
- Reset values: state=RUN, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_halted=0.
- While `reset`=1, the combinational outputs are forced: `cpu_stall`=0, `dbg_ready`=0, `ram_mem_op`=`MEM_OP_NOP`.
- CPU access: zero added latency when granted.
- Debug write: commits in the grant cycle.
- Debug read: data arrives 1 cycle after the grant.
- Halt latency: `dbg_halted` and `cpu_stall` rise the cycle after `dbg_halt_req` first samples high, and fall the cycle after it samples low. `dbg_halt_req` has no combinational effect.
- Simultaneous events:
  - Forced slot and `dbg_halt_req` in the same cycle: the forced slot is served, then HALT.
  - `dbg_valid` dropped mid-wait: the counter clears and no grant is issued.
- Reset mid-HALT returns to RUN. Any pending `dbg_rvalid` is lost.

## Structure
- `MEM_OP_NOP`/`READ`/`WRITE`, `` `MEM_OP_BITS ``, `` `ADDR_WIDTH `` and `` `DATA_WIDTH `` live in the shared `defines.vh`. No new global constants are needed.
- FSM state encodings are local parameters.
- One sub-module, `arb_wait_counter`: saturating counter with inputs inc and clr, and an `at_limit` flag.

## Test plan
- CPU-only stream (4 LW/SW, `dbg_valid`=0) → every op reaches ram in the same cycle; `cpu_stall` is never 1.
- CPU idle, debug write 0x1234 to addr 0x10, then read 0x10 → `dbg_ready`=1 in both cycles; `dbg_rvalid`=1 with `dbg_rdata`=0x1234 one cycle after the read.
- CPU issues back-to-back memory ops while debug reads with STARVE_LIMIT=4 → `dbg_ready` rises on cycle 5 with `cpu_stall`=1 for exactly that cycle; the CPU op replays next cycle; `wait_cnt` returns to 0.
- `dbg_halt_req` held 6 cycles with 3 debug writes → `dbg_halted`/`cpu_stall` high cycles 1–6; CPU ops are never seen on the ram port; the CPU resumes the cycle after release.
- Reset asserted during HALT with a debug read accepted → next cycle: state RUN, `dbg_halted`=0, `dbg_rvalid`=0.
- Forced slot coincident with `dbg_halt_req` rising → debug is served once with a stall, then HALT; no CPU op is lost or duplicated in memory contents.
